// File: rtl/elevator_status_display.sv
// Status display for the elevator controller: multiplexed 4-digit 7-segment
// readout, per-floor request LEDs and alarm LED/buzzer with blink and hold-off.
module elevator_status_display #(
  parameter int floor     = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000,
  parameter int HOLD_CYC  = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [floor-1:0] currentFloor,
  input  logic             movingUp,
  input  logic             movingDown,
  input  logic             doorOpen,
  input  logic             fault,
  input  logic [floor-1:0] queueUp,
  input  logic [floor-1:0] queueDown,
  input  logic [floor-1:0] queueinside,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic [floor-1:0] reqLed,
  output logic             alarmLed,
  output logic             buzzer
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, ALARM, HOLD} alarm_state_e;

  alarm_state_e    state_q, state_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      digit_idx_q, digit_idx_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic [floor-1:0] req_q, req_d;
  logic            alarm_led_q, alarm_led_d;
  logic            buzzer_q, buzzer_d;

  logic [3:0]      floor_hits;
  logic [3:0]      floor_num;
  logic            bad_floor;
  logic            dir_conflict;
  logic            fault_eff;

  function automatic logic [6:0] num_seg(input logic [3:0] num);
    case (num)
      4'd1:    num_seg = 7'b1111001;
      4'd2:    num_seg = 7'b0100100;
      4'd3:    num_seg = 7'b0110000;
      4'd4:    num_seg = 7'b0011001;
      4'd5:    num_seg = 7'b0010010;
      4'd6:    num_seg = 7'b0000010;
      4'd7:    num_seg = 7'b1111000;
      4'd8:    num_seg = 7'b0000000;
      4'd9:    num_seg = 7'b0010000;
      default: num_seg = SEG_E;
    endcase
  endfunction

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    floor_hits = '0;
    floor_num  = '0;
    for (int i = 0; i < floor; i++) begin
      if (currentFloor[i]) begin
        floor_hits = floor_hits + 4'd1;
        floor_num  = 4'(i + 1);
      end
    end
  end

  assign bad_floor    = (floor_hits != 4'd1);
  assign dir_conflict = movingUp & movingDown;
  assign fault_eff    = fault | bad_floor | dir_conflict;

  always_comb begin
    scan_cnt_d  = scan_cnt_q + SW'(1);
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end

    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  // Digit content follows live inputs so the readout keeps updating during an alarm.
  always_comb begin
    seg_d = SEG_BLANK;
    unique case (digit_idx_q)
      2'd0: seg_d = bad_floor ? SEG_E : num_seg(floor_num);
      2'd1: begin
        if (dir_conflict)    seg_d = SEG_E;
        else if (movingUp)   seg_d = SEG_U;
        else if (movingDown) seg_d = SEG_D;
        else                 seg_d = SEG_DASH;
      end
      2'd2: seg_d = doorOpen ? SEG_O : SEG_C;
      2'd3: seg_d = (state_q != IDLE) ? SEG_F : SEG_BLANK;
    endcase
    an_d  = ~(4'b0001 << digit_idx_q);
    req_d = queueUp | queueDown | queueinside;
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    alarm_led_d = 1'b0;
    buzzer_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fault_eff) state_d = ALARM;
      end
      ALARM: begin
        alarm_led_d = blink_q;
        buzzer_d    = blink_q;
        if (!fault_eff) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        alarm_led_d = 1'b1;
        // A new fault re-arms before the hold-off can expire.
        if (fault_eff)                               state_d    = ALARM;
        else if (hold_cnt_q == HW'(HOLD_CYC - 1))    state_d    = IDLE;
        else                                         hold_cnt_d = hold_cnt_q + HW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      hold_cnt_q  <= '0;
      seg_q       <= 7'h7F;
      an_q        <= 4'hF;
      req_q       <= '0;
      alarm_led_q <= 1'b0;
      buzzer_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      hold_cnt_q  <= hold_cnt_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      req_q       <= req_d;
      alarm_led_q <= alarm_led_d;
      buzzer_q    <= buzzer_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign reqLed   = req_q;
  assign alarmLed = alarm_led_q;
  assign buzzer   = buzzer_q;

endmodule

// File: tb/tb_elevator_status_display.sv
// Bench for elevator_status_display: vector table, multi-cycle alarm/reset
// sequences, and randomized inputs against a time-based reference model.
module tb_elevator_status_display;

  localparam int FL    = 6;
  localparam int SCAN  = 4;
  localparam int BLINK = 8;
  localparam int HOLD  = 16;

  localparam logic [6:0] S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010;
  localparam logic [6:0] SE = 7'b0000110, SU = 7'b1000001, SD = 7'b0100001;
  localparam logic [6:0] SM = 7'b0111111, SO = 7'b1000000, SC = 7'b1000110;
  localparam logic [6:0] SF = 7'b0001110, SB = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FL-1:0] cur_floor = 6'b000100;
  logic          mv_up = 1'b0, mv_dn = 1'b0, door = 1'b0, flt = 1'b0;
  logic [FL-1:0] q_up = '0, q_dn = '0, q_in = '0;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic [FL-1:0] req_led;
  logic          alarm_led, buzzer;

  int total = 0;
  int bad   = 0;

  // Reference model state: edges since reset release, and edges since the
  // last edge that saw an effective fault (HOLD+1 means "quiet").
  int            n     = 0;
  int            since = HOLD + 1;
  bit            chk_model = 1'b0;
  logic [6:0]    exp_seg;
  logic [3:0]    exp_an;
  logic [FL-1:0] exp_req;
  logic          exp_alarm, exp_buzz;

  elevator_status_display #(
    .floor(FL), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .currentFloor(cur_floor),
    .movingUp(mv_up), .movingDown(mv_dn), .doorOpen(door), .fault(flt),
    .queueUp(q_up), .queueDown(q_dn), .queueinside(q_in),
    .seg(seg), .an(an), .reqLed(req_led), .alarmLed(alarm_led), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      1: seg_of = S1;  2: seg_of = S2;  3: seg_of = S3;
      4: seg_of = S4;  5: seg_of = S5;  6: seg_of = S6;
      default: seg_of = SE;
    endcase
  endfunction

  task automatic model_update();
    int  hits, fl, idx;
    bit  fe, was_alarm, was_hold, blink;
    hits = 0;
    fl   = 0;
    for (int i = 0; i < FL; i++)
      if (cur_floor[i]) begin hits++; fl = i + 1; end
    n++;
    fe        = flt || (hits != 1) || (mv_up && mv_dn);
    was_alarm = (since == 0);
    was_hold  = (since >= 1) && (since <= HOLD);
    blink     = (((n - 1) / BLINK) % 2) == 1;
    idx       = ((n - 1) / SCAN) % 4;
    case (idx)
      0: exp_seg = (hits != 1) ? SE : seg_of(fl);
      1: exp_seg = (mv_up && mv_dn) ? SE : mv_up ? SU : mv_dn ? SD : SM;
      2: exp_seg = door ? SO : SC;
      default: exp_seg = (was_alarm || was_hold) ? SF : SB;
    endcase
    exp_an    = ~(4'b0001 << idx);
    exp_req   = q_up | q_dn | q_in;
    exp_alarm = was_alarm ? blink : was_hold;
    exp_buzz  = was_alarm && blink;
    since     = fe ? 0 : (since > HOLD ? since : since + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
    if (chk_model)
      check("model", 32'({seg, an, req_led, alarm_led, buzzer}),
            32'({exp_seg, exp_an, exp_req, exp_alarm, exp_buzz}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_out", 32'({req_led, alarm_led, buzzer}), 32'h0);
    rst   = 1'b0;
    n     = 0;
    since = HOLD + 1;
  endtask

  task automatic idle_inputs();
    cur_floor = 6'b000100;
    {mv_up, mv_dn, door, flt} = 4'b0000;
    q_up = '0; q_dn = '0; q_in = '0;
  endtask

  typedef struct {
    logic [FL-1:0] fl;
    logic          up, dn, dr, ft;
    logic [FL-1:0] qu, qd, qi;
    logic [6:0]    d0, d1, d2, d3;
    logic [FL-1:0] req;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [3:0] an_seq[4];
    logic [6:0] seg_seq[4];
    logic [6:0] cap[4];
    logic       prev_b;
    int         last_t, ntog, errs;
    bit         seen;

    an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_seq = '{S3, SM, SC, SB};

    vecs[0] = '{6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, S3, SM, SC, SB, 6'b000000};
    vecs[1] = '{6'b000001, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b000000, 6'b100000, S1, SU, SC, SB, 6'b100001};
    vecs[2] = '{6'b100000, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 6'b010010, 6'b000000, S6, SD, SO, SB, 6'b010010};
    vecs[3] = '{6'b010000, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 6'b000000, 6'b000000, S5, SM, SO, SB, 6'b000000};
    vecs[4] = '{6'b001000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100, 6'b001000, 6'b000001, S4, SM, SC, SB, 6'b001101};
    vecs[5] = '{6'b000010, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 6'b000000, 6'b000000, S2, SM, SC, SF, 6'b000000};
    vecs[6] = '{6'b000110, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, SE, SM, SC, SF, 6'b000000};
    vecs[7] = '{6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, SE, SU, SC, SF, 6'b000000};
    vecs[8] = '{6'b000001, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, S1, SE, SC, SF, 6'b000000};
    vecs[9] = '{6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, S3, SM, SC, SB, 6'b000000};

    // Reset and basic scan order.
    idle_inputs();
    do_reset();
    #1;
    check("an_before_first_edge", 32'(an), 32'hF);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("scan_an", 32'(an), 32'(an_seq[(i - 1) / 4]));
      check("scan_seg", 32'(seg), 32'(seg_seq[(i - 1) / 4]));
    end

    // Request LEDs: one-cycle latency both ways.
    q_in = 6'b100000;
    q_up = 6'b000001;
    #1;
    check("req_before_edge", 32'(req_led), 32'h0);
    tick();
    check("req_set", 32'(req_led), 32'(6'b100001));
    q_in = '0;
    q_up = '0;
    tick();
    check("req_clear", 32'(req_led), 32'h0);

    // Vector table: settle, then capture each digit over a full scan.
    for (int v = 0; v < 10; v++) begin
      cur_floor = vecs[v].fl;
      mv_up = vecs[v].up; mv_dn = vecs[v].dn; door = vecs[v].dr; flt = vecs[v].ft;
      q_up = vecs[v].qu; q_dn = vecs[v].qd; q_in = vecs[v].qi;
      repeat (20) tick();
      cap = '{7'bx, 7'bx, 7'bx, 7'bx};
      for (int c = 0; c < 16; c++) begin
        tick();
        case (an)
          4'b1110: cap[0] = seg;
          4'b1101: cap[1] = seg;
          4'b1011: cap[2] = seg;
          4'b0111: cap[3] = seg;
          default: ;
        endcase
      end
      check($sformatf("vec%0d_d0", v), 32'(cap[0]), 32'(vecs[v].d0));
      check($sformatf("vec%0d_d1", v), 32'(cap[1]), 32'(vecs[v].d1));
      check($sformatf("vec%0d_d2", v), 32'(cap[2]), 32'(vecs[v].d2));
      check($sformatf("vec%0d_d3", v), 32'(cap[3]), 32'(vecs[v].d3));
      check($sformatf("vec%0d_req", v), 32'(req_led), 32'(vecs[v].req));
    end

    // Fault pulse of 20 clocks: buzzer period, F digit, then hold-off.
    idle_inputs();
    tick();
    flt    = 1'b1;
    prev_b = 1'b0;
    last_t = -1;
    ntog   = 0;
    errs   = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i > 2 && buzzer !== prev_b) begin
        if (last_t >= 0) check("buzz_period", 32'(i - last_t), 32'(BLINK));
        last_t = i;
        ntog++;
      end
      if (i >= 2) begin
        prev_b = buzzer;
        if (alarm_led !== buzzer) errs++;
        if (an == 4'b0111) begin
          seen = 1'b1;
          if (seg !== SF) errs++;
        end
      end
    end
    check("buzz_toggles", 32'(ntog >= 2), 32'h1);
    check("alarm_f_digit", 32'({seen, errs == 0}), 32'h3);
    flt = 1'b0;
    tick();
    errs = 0;
    for (int j = 0; j < HOLD; j++) begin
      tick();
      if ({alarm_led, buzzer} !== 2'b10) errs++;
    end
    check("hold_lit_cycles_bad", 32'(errs), 32'h0);
    tick();
    check("hold_expire", 32'({alarm_led, buzzer}), 32'h0);

    // Asynchronous reset in the middle of an alarm.
    flt  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * BLINK + 4 && !seen; i++) begin
      tick();
      if (buzzer === 1'b1) seen = 1'b1;
    end
    check("buzz_seen", 32'(seen), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_seg", 32'(seg), 32'h7F);
    check("async_an", 32'(an), 32'hF);
    check("async_alarm", 32'({alarm_led, buzzer}), 32'h0);
    idle_inputs();
    do_reset();

    // Randomized stimulus against the reference model.
    chk_model = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        bit noisy;
        int r;
        noisy = (c % 300) < 150;
        cur_floor = 6'b000001 << $urandom_range(0, FL - 1);
        if (noisy && $urandom_range(0, 6) == 0) cur_floor = 6'($urandom_range(0, 63));
        r = $urandom_range(0, 9);
        mv_up = (r >= 4 && r <= 6) || (noisy && r == 9);
        mv_dn = (r >= 7);
        if (!noisy && r == 9) mv_dn = 1'b0;
        door = 1'($urandom_range(0, 1));
        flt  = noisy && ($urandom_range(0, 7) == 0);
        q_up = 6'($urandom_range(0, 63));
        q_dn = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
        q_in = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
      end
      tick();
    end
    chk_model = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
